// File: rtl/lisnoc_dma_request_table.sv
// Request table of the LiSNoC DMA: descriptor storage, per-entry valid/started/done
// tracking and a round-robin picker presenting pending entries to the control engine.
module lisnoc_dma_request_table #(
    parameter int table_entries = 4,
    parameter int laddr_width   = 32,
    parameter int size_width    = 32,
    parameter int rtile_width   = 16,
    parameter int raddr_width   = 32,
    localparam int REQ_W = laddr_width + size_width + rtile_width + raddr_width + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REQ_W-1:0]         if_write_req,
    input  logic [1:0]               if_write_pos,
    input  logic [4:0]               if_write_select,
    input  logic                     if_write_en,
    input  logic [1:0]               if_valid_pos,
    input  logic                     if_valid_set,
    input  logic                     if_valid_en,
    input  logic                     if_validrd_en,
    output logic [table_entries-1:0] done,
    output logic [table_entries-1:0] valid,
    output logic [REQ_W-1:0]         ctrl_req,
    output logic [1:0]               ctrl_req_pos,
    output logic                     ctrl_req_valid,
    input  logic                     ctrl_req_ack,
    input  logic [1:0]               ctrl_done_pos,
    input  logic                     ctrl_done_en
);

    localparam int RADDR_LSB = 1;
    localparam int RTILE_LSB = RADDR_LSB + raddr_width;
    localparam int SIZE_LSB  = RTILE_LSB + rtile_width;
    localparam int LADDR_LSB = SIZE_LSB + size_width;

    logic [REQ_W-1:0]         req_mem [table_entries];
    logic [table_entries-1:0] started;
    logic [1:0]               rr;

    logic [REQ_W-1:0]         field_mask;
    logic [table_entries-1:0] pending;
    logic [table_entries-1:0] valid_n, started_n, done_n;
    logic [1:0]               cand, pick;
    logic                     found, ack;

    always_comb begin
        field_mask = '0;
        if (if_write_select[0]) field_mask[LADDR_LSB +: laddr_width] = '1;
        if (if_write_select[1]) field_mask[SIZE_LSB +: size_width]   = '1;
        if (if_write_select[2]) field_mask[RTILE_LSB +: rtile_width] = '1;
        if (if_write_select[3]) field_mask[RADDR_LSB +: raddr_width] = '1;
        if (if_write_select[4]) field_mask[0]                        = 1'b1;
    end

    // Round-robin search starting at rr, wrapping over the table
    always_comb begin
        pending = valid & ~started & ~done;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = 0; k < table_entries; k++) begin
            cand = 2'((int'(rr) + k) % table_entries);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        ctrl_req_valid = found;
        ctrl_req_pos   = pick;
        ctrl_req       = found ? req_mem[pick] : '0;
        ack            = ctrl_req_ack && found;
    end

    // Later updates override earlier ones: status accesses (abort/free) win over ack/done
    always_comb begin
        valid_n   = valid;
        started_n = started;
        done_n    = done;
        for (int i = 0; i < table_entries; i++) begin
            if (ack && pick == 2'(i))
                started_n[i] = 1'b1;
            if (ctrl_done_en && ctrl_done_pos == 2'(i) && valid[i] && started[i] && !done[i]) begin
                started_n[i] = 1'b0;
                done_n[i]    = 1'b1;
            end
            if (if_valid_en && if_valid_pos == 2'(i)) begin
                if (!if_valid_set) begin
                    valid_n[i]   = 1'b0;
                    started_n[i] = 1'b0;
                    done_n[i]    = 1'b0;
                end else if (!valid[i]) begin
                    valid_n[i]   = 1'b1;
                    started_n[i] = 1'b0;
                    done_n[i]    = 1'b0;
                end
            end
            if (if_validrd_en && if_valid_pos == 2'(i) && !if_valid_set) begin
                valid_n[i]   = 1'b0;
                started_n[i] = 1'b0;
                done_n[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            started <= '0;
            done    <= '0;
            rr      <= '0;
            for (int i = 0; i < table_entries; i++)
                req_mem[i] <= '0;
        end else begin
            valid   <= valid_n;
            started <= started_n;
            done    <= done_n;
            if (ack)
                rr <= 2'((int'(pick) + 1) % table_entries);
            if (if_write_en && !valid[if_write_pos])
                req_mem[if_write_pos] <= (req_mem[if_write_pos] & ~field_mask)
                                       | (if_write_req & field_mask);
        end
    end

endmodule

// File: tb/tb_lisnoc_dma_request_table.sv
// Directed bench for lisnoc_dma_request_table: descriptor writes, scheduling order,
// completion/free handshake and same-cycle collision cases.
module tb_lisnoc_dma_request_table;

    localparam int REQ_W = 113;

    logic             clk = 1'b0;
    logic             rst;
    logic [REQ_W-1:0] if_write_req;
    logic [1:0]       if_write_pos;
    logic [4:0]       if_write_select;
    logic             if_write_en;
    logic [1:0]       if_valid_pos;
    logic             if_valid_set;
    logic             if_valid_en;
    logic             if_validrd_en;
    logic [3:0]       done;
    logic [3:0]       valid;
    logic [REQ_W-1:0] ctrl_req;
    logic [1:0]       ctrl_req_pos;
    logic             ctrl_req_valid;
    logic             ctrl_req_ack;
    logic [1:0]       ctrl_done_pos;
    logic             ctrl_done_en;

    int checks = 0;
    int failures = 0;

    lisnoc_dma_request_table dut (
        .clk(clk), .rst(rst),
        .if_write_req(if_write_req), .if_write_pos(if_write_pos),
        .if_write_select(if_write_select), .if_write_en(if_write_en),
        .if_valid_pos(if_valid_pos), .if_valid_set(if_valid_set),
        .if_valid_en(if_valid_en), .if_validrd_en(if_validrd_en),
        .done(done), .valid(valid),
        .ctrl_req(ctrl_req), .ctrl_req_pos(ctrl_req_pos), .ctrl_req_valid(ctrl_req_valid),
        .ctrl_req_ack(ctrl_req_ack), .ctrl_done_pos(ctrl_done_pos), .ctrl_done_en(ctrl_done_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if_write_en   = 1'b0;
        if_valid_en   = 1'b0;
        if_validrd_en = 1'b0;
        ctrl_req_ack  = 1'b0;
        ctrl_done_en  = 1'b0;
    endtask

    task automatic write_field(input logic [1:0] pos, input logic [4:0] sel, input logic [31:0] data);
        if_write_req    = {data, data, data[15:0], data, data[0]};
        if_write_pos    = pos;
        if_write_select = sel;
        if_write_en     = 1'b1;
        tick();
    endtask

    task automatic status_write(input logic [1:0] pos, input logic set);
        if_valid_pos = pos;
        if_valid_set = set;
        if_valid_en  = 1'b1;
        tick();
    endtask

    task automatic status_read(input logic [1:0] pos, input logic set);
        if_valid_pos  = pos;
        if_valid_set  = set;
        if_validrd_en = 1'b1;
        tick();
    endtask

    task automatic complete(input logic [1:0] pos);
        ctrl_done_pos = pos;
        ctrl_done_en  = 1'b1;
        tick();
    endtask

    task automatic do_ack();
        ctrl_req_ack = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", valid); end
        checks++; if (ctrl_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", ctrl_req_valid); end
        checks++; if (ctrl_req_pos !== 2'd0) begin failures++; $display("FAIL reset_req_pos got=%0d exp=0", ctrl_req_pos); end
        checks++; if (ctrl_req !== '0) begin failures++; $display("FAIL reset_req got=%h exp=0", ctrl_req); end
    endtask

    task automatic test_single_request();
        logic [REQ_W-1:0] exp_req;
        exp_req = {32'h1000, 32'h10, 16'h3, 32'h2000, 1'b1};
        write_field(2'd2, 5'b00001, 32'h1000);
        write_field(2'd2, 5'b00010, 32'h10);
        write_field(2'd2, 5'b00100, 32'h3);
        write_field(2'd2, 5'b01000, 32'h2000);
        write_field(2'd2, 5'b10000, 32'h1);
        write_field(2'd2, 5'b00000, 32'hFFFF_FFFF);
        checks++; if (ctrl_req_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", ctrl_req_valid); end
        status_write(2'd2, 1'b1);
        checks++; if (valid !== 4'b0100) begin failures++; $display("FAIL single_valid got=%b exp=0100", valid); end
        checks++; if (ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL single_req_valid got=%b exp=1", ctrl_req_valid); end
        checks++; if (ctrl_req_pos !== 2'd2) begin failures++; $display("FAIL single_pos got=%0d exp=2", ctrl_req_pos); end
        checks++; if (ctrl_req !== exp_req) begin failures++; $display("FAIL single_req got=%h exp=%h", ctrl_req, exp_req); end
        status_write(2'd2, 1'b0);
        checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL abort_valid got=%b exp=0000", valid); end
        checks++; if (ctrl_req_valid !== 1'b0) begin failures++; $display("FAIL abort_req_valid got=%b exp=0", ctrl_req_valid); end
    endtask

    task automatic test_round_robin();
        write_field(2'd0, 5'b00001, 32'h1000);
        write_field(2'd1, 5'b00001, 32'h1100);
        write_field(2'd3, 5'b00001, 32'h1300);
        status_write(2'd0, 1'b1);
        status_write(2'd1, 1'b1);
        status_write(2'd3, 1'b1);
        checks++; if (ctrl_req_pos !== 2'd0 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rr_first got=%0d/%b exp=0/1", ctrl_req_pos, ctrl_req_valid); end
        checks++; if (ctrl_req[112:81] !== 32'h1000) begin failures++; $display("FAIL rr_first_laddr got=%h exp=1000", ctrl_req[112:81]); end
        do_ack();
        checks++; if (ctrl_req_pos !== 2'd1 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rr_second got=%0d/%b exp=1/1", ctrl_req_pos, ctrl_req_valid); end
        do_ack();
        checks++; if (ctrl_req_pos !== 2'd3 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rr_third got=%0d/%b exp=3/1", ctrl_req_pos, ctrl_req_valid); end
        checks++; if (ctrl_req[112:81] !== 32'h1300) begin failures++; $display("FAIL rr_third_laddr got=%h exp=1300", ctrl_req[112:81]); end
        do_ack();
        checks++; if (ctrl_req_valid !== 1'b0 || ctrl_req_pos !== 2'd0) begin failures++; $display("FAIL rr_empty got=%0d/%b exp=0/0", ctrl_req_pos, ctrl_req_valid); end
        do_ack();
        checks++; if (valid !== 4'b1011 || done !== 4'b0000) begin failures++; $display("FAIL rr_stray_ack got=%b/%b exp=1011/0000", valid, done); end
    endtask

    task automatic test_done_free();
        complete(2'd1);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL done_set got=%b exp=0010", done); end
        checks++; if (valid !== 4'b1011) begin failures++; $display("FAIL done_valid got=%b exp=1011", valid); end
        complete(2'd2);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL done_on_free got=%b exp=0010", done); end
        status_read(2'd1, 1'b0);
        checks++; if (valid !== 4'b1001 || done !== 4'b0000) begin failures++; $display("FAIL free_read got=%b/%b exp=1001/0000", valid, done); end
        complete(2'd3);
        status_read(2'd3, 1'b0);
        status_write(2'd1, 1'b1);
        status_write(2'd3, 1'b1);
        checks++; if (ctrl_req_pos !== 2'd1 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rr_wrap got=%0d/%b exp=1/1", ctrl_req_pos, ctrl_req_valid); end
        do_ack();
        checks++; if (ctrl_req_pos !== 2'd3 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rr_wrap_next got=%0d/%b exp=3/1", ctrl_req_pos, ctrl_req_valid); end
        do_ack();
    endtask

    task automatic test_write_protect();
        write_field(2'd0, 5'b00001, 32'hDEAD);
        complete(2'd0);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL wp_done got=%b exp=0001", done); end
        status_read(2'd0, 1'b0);
        status_write(2'd0, 1'b1);
        checks++; if (ctrl_req_pos !== 2'd0 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL wp_pick got=%0d/%b exp=0/1", ctrl_req_pos, ctrl_req_valid); end
        checks++; if (ctrl_req[112:81] !== 32'h1000) begin failures++; $display("FAIL wp_laddr got=%h exp=1000", ctrl_req[112:81]); end
    endtask

    task automatic test_read_done_same_cycle();
        status_write(2'd2, 1'b1);
        do_ack();
        checks++; if (ctrl_req_pos !== 2'd2 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL rd_pick got=%0d/%b exp=2/1", ctrl_req_pos, ctrl_req_valid); end
        do_ack();
        if_valid_pos  = 2'd2;
        if_valid_set  = 1'b1;
        if_validrd_en = 1'b1;
        ctrl_done_pos = 2'd2;
        ctrl_done_en  = 1'b1;
        tick();
        checks++; if (valid !== 4'b1111) begin failures++; $display("FAIL rd_same_valid got=%b exp=1111", valid); end
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL rd_same_done got=%b exp=0100", done); end
    endtask

    task automatic test_abort_vs_ack();
        status_read(2'd2, 1'b0);
        status_write(2'd2, 1'b1);
        checks++; if (ctrl_req_pos !== 2'd2 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL abort_pick got=%0d/%b exp=2/1", ctrl_req_pos, ctrl_req_valid); end
        ctrl_req_ack = 1'b1;
        if_valid_pos = 2'd2;
        if_valid_set = 1'b0;
        if_valid_en  = 1'b1;
        tick();
        checks++; if (valid !== 4'b1011 || ctrl_req_valid !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b/%b exp=1011/0", valid, ctrl_req_valid); end
        complete(2'd2);
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abort_done got=%b exp=0000", done); end
    endtask

    task automatic test_back_to_back();
        complete(2'd3);
        status_read(2'd3, 1'b0);
        checks++; if (valid !== 4'b0011) begin failures++; $display("FAIL b2b_setup got=%b exp=0011", valid); end
        status_write(2'd2, 1'b1);
        ctrl_req_ack = 1'b1;
        if_valid_pos = 2'd3;
        if_valid_set = 1'b1;
        if_valid_en  = 1'b1;
        tick();
        checks++; if (valid !== 4'b1111) begin failures++; $display("FAIL b2b_valid got=%b exp=1111", valid); end
        checks++; if (ctrl_req_pos !== 2'd3 || ctrl_req_valid !== 1'b1) begin failures++; $display("FAIL b2b_pick got=%0d/%b exp=3/1", ctrl_req_pos, ctrl_req_valid); end
    endtask

    task automatic test_reset_mid();
        do_ack();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (valid !== 4'b0000 || done !== 4'b0000) begin failures++; $display("FAIL rst_mid_state got=%b/%b exp=0000/0000", valid, done); end
        checks++; if (ctrl_req_valid !== 1'b0 || ctrl_req !== '0) begin failures++; $display("FAIL rst_mid_req got=%b/%h exp=0/0", ctrl_req_valid, ctrl_req); end
        complete(2'd3);
        checks++; if (done !== 4'b0000 || valid !== 4'b0000) begin failures++; $display("FAIL rst_mid_done got=%b/%b exp=0000/0000", done, valid); end
    endtask

    initial begin
        rst = 1'b1;
        if_write_req = '0; if_write_pos = '0; if_write_select = '0; if_write_en = 1'b0;
        if_valid_pos = '0; if_valid_set = 1'b0; if_valid_en = 1'b0; if_validrd_en = 1'b0;
        ctrl_req_ack = 1'b0; ctrl_done_pos = '0; ctrl_done_en = 1'b0;
        test_reset();
        test_single_request();
        test_round_robin();
        test_done_free();
        test_write_protect();
        test_read_done_same_cycle();
        test_abort_vs_ack();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
